// File: rtl/mic_frame_buffer.sv
// Double-buffered capture of decimated microphone samples into SAMPLES-word frames.
// Each completed frame is handed to the FFT through a valid/ack handshake.
module mic_frame_buffer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SAMPLES = 16,
  parameter int unsigned DECIM   = 1
) (
  input  logic                       adc_clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           sample_in,
  input  logic                       sample_valid,
  output logic [SAMPLES*WIDTH-1:0]   frame_out,
  output logic                       frame_valid,
  input  logic                       frame_ack,
  output logic                       filling_bank,
  output logic [15:0]                frame_count,
  output logic [15:0]                overflow_count
);

  localparam int unsigned IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
  localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic {FILL, STALL} state_t;

  state_t           r_state;
  logic [IW-1:0]    r_wr_idx;
  logic [DW-1:0]    r_dec;
  logic             r_wr_bank;
  logic             r_rd_bank;
  logic             r_valid;
  logic [15:0]      r_frame_cnt;
  logic [15:0]      r_ovf_cnt;
  logic [WIDTH-1:0] r_mem [2][SAMPLES];

  logic w_elig;
  logic w_last;
  logic w_write;

  assign w_elig  = sample_valid && (r_dec == '0);
  assign w_last  = (r_wr_idx == IW'(SAMPLES - 1));
  assign w_write = !reset && (r_state == FILL) && w_elig;

  // Storage is never cleared; only the write side depends on reset.
  always_ff @(posedge adc_clk) begin
    if (w_write) r_mem[r_wr_bank][r_wr_idx] <= sample_in;
  end

  // While stalled, r_wr_bank is the completed (pending) bank, so a publish
  // out of STALL is just a swap of the read and write banks.
  always_ff @(posedge adc_clk) begin
    if (reset) begin
      r_state     <= FILL;
      r_wr_idx    <= '0;
      r_dec       <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_cnt <= '0;
      r_ovf_cnt   <= '0;
    end else begin
      if (sample_valid)
        r_dec <= (r_dec == DW'(DECIM - 1)) ? '0 : r_dec + DW'(1);

      case (r_state)
        FILL: begin
          if (w_elig && w_last) begin
            if (!r_valid || frame_ack) begin
              r_rd_bank   <= r_wr_bank;
              r_valid     <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
              r_wr_bank   <= ~r_wr_bank;
              r_wr_idx    <= '0;
            end else begin
              r_state <= STALL;
            end
          end else begin
            if (w_elig) r_wr_idx <= r_wr_idx + IW'(1);
            if (r_valid && frame_ack) r_valid <= 1'b0;
          end
        end
        STALL: begin
          if (w_elig && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
          if (frame_ack) begin
            r_rd_bank   <= r_wr_bank;
            r_wr_bank   <= r_rd_bank;
            r_wr_idx    <= '0;
            r_frame_cnt <= r_frame_cnt + 16'd1;
            r_state     <= FILL;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  always_comb begin
    frame_out = '0;
    for (int unsigned k = 0; k < SAMPLES; k++)
      frame_out[k*WIDTH +: WIDTH] = r_mem[r_rd_bank][k];
  end

  assign frame_valid    = r_valid;
  assign filling_bank   = r_wr_bank;
  assign frame_count    = r_frame_cnt;
  assign overflow_count = r_ovf_cnt;

endmodule

// File: tb/tb_mic_frame_buffer.sv
// Directed bench for mic_frame_buffer: one DUT with DECIM=1, one with DECIM=4,
// sharing stimulus; outputs are sampled 1 time unit after the rising edge.
module tb_mic_frame_buffer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned SAMPLES = 16;

  logic                     adc_clk = 1'b0;
  logic                     reset;
  logic [WIDTH-1:0]         sample_in;
  logic                     sample_valid;
  logic                     frame_ack;

  logic [SAMPLES*WIDTH-1:0] f1_out,   f4_out;
  logic                     f1_valid, f4_valid;
  logic                     f1_bank,  f4_bank;
  logic [15:0]              f1_cnt,   f4_cnt;
  logic [15:0]              f1_ovf,   f4_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 adc_clk = ~adc_clk;

  mic_frame_buffer #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .DECIM(1)) dut1 (
    .adc_clk(adc_clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .frame_out(f1_out), .frame_valid(f1_valid), .frame_ack(frame_ack),
    .filling_bank(f1_bank), .frame_count(f1_cnt), .overflow_count(f1_ovf)
  );

  mic_frame_buffer #(.WIDTH(WIDTH), .SAMPLES(SAMPLES), .DECIM(4)) dut4 (
    .adc_clk(adc_clk), .reset(reset), .sample_in(sample_in), .sample_valid(sample_valid),
    .frame_out(f4_out), .frame_valid(f4_valid), .frame_ack(frame_ack),
    .filling_bank(f4_bank), .frame_count(f4_cnt), .overflow_count(f4_ovf)
  );

  function automatic logic [WIDTH-1:0] word(input logic [SAMPLES*WIDTH-1:0] f, input int k);
    return f[k*WIDTH +: WIDTH];
  endfunction

  task automatic tick();
    @(posedge adc_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sample_valid = 1'b0; frame_ack = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Streams n consecutive samples start, start+1, ...
  task automatic feed(input logic [WIDTH-1:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      sample_in = start + WIDTH'(i); sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_checks++;
    if (f1_valid !== 1'b0 || f1_bank !== 1'b0 || f1_cnt !== 16'd0 || f1_ovf !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b bank=%b cnt=%0d ovf=%0d, want 0 0 0 0",
               f1_valid, f1_bank, f1_cnt, f1_ovf);
    end
  endtask

  task automatic test_first_frame();
    feed(32'h1, 15);
    n_checks++;
    if (f1_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_valid: valid=%b after 15 samples, want 0", f1_valid);
    end
    feed(32'h10, 1);
    n_checks++;
    if (f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h1 || word(f1_out, 15) !== 32'h10 ||
        f1_cnt !== 16'd1 || f1_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL first_frame: valid=%b w0=%h w15=%h cnt=%0d bank=%b, want 1 1 10 1 1",
               f1_valid, word(f1_out, 0), word(f1_out, 15), f1_cnt, f1_bank);
    end
  endtask

  task automatic test_stall();
    feed(32'h11, 16);
    n_checks++;
    if (f1_valid !== 1'b1 || f1_cnt !== 16'd1 || f1_bank !== 1'b1 || f1_ovf !== 16'd0) begin
      n_fail++;
      $display("FAIL stall_entry: valid=%b cnt=%0d bank=%b ovf=%0d, want 1 1 1 0",
               f1_valid, f1_cnt, f1_bank, f1_ovf);
    end
    feed(32'h21, 5);
    n_checks++;
    if (f1_ovf !== 16'd5 || f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h1 || f1_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_hold: ovf=%0d valid=%b w0=%h cnt=%0d, want 5 1 1 1",
               f1_ovf, f1_valid, word(f1_out, 0), f1_cnt);
    end
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_checks++;
    if (f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h11 || word(f1_out, 15) !== 32'h20 ||
        f1_cnt !== 16'd2 || f1_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b w0=%h w15=%h cnt=%0d bank=%b, want 1 11 20 2 0",
               f1_valid, word(f1_out, 0), word(f1_out, 15), f1_cnt, f1_bank);
    end
  endtask

  task automatic test_mid_ack();
    feed(32'h31, 7);
    sample_in = 32'h38; sample_valid = 1'b1; frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    n_checks++;
    if (f1_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_ack_drop: valid=%b, want 0", f1_valid);
    end
    feed(32'h39, 7);
    n_checks++;
    if (f1_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_ack_early: valid=%b after 15 samples, want 0", f1_valid);
    end
    feed(32'h40, 1);
    n_checks++;
    if (f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h31 || word(f1_out, 15) !== 32'h40 ||
        f1_cnt !== 16'd3 || f1_ovf !== 16'd5) begin
      n_fail++;
      $display("FAIL mid_ack_frame: valid=%b w0=%h w15=%h cnt=%0d ovf=%0d, want 1 31 40 3 5",
               f1_valid, word(f1_out, 0), word(f1_out, 15), f1_cnt, f1_ovf);
    end
  endtask

  task automatic test_back_to_back();
    feed(32'h41, 15);
    sample_in = 32'h50; sample_valid = 1'b1; frame_ack = 1'b1;
    tick();
    sample_valid = 1'b0; frame_ack = 1'b0;
    n_checks++;
    if (f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h41 || word(f1_out, 15) !== 32'h50 ||
        f1_cnt !== 16'd4 || f1_ovf !== 16'd5) begin
      n_fail++;
      $display("FAIL same_cycle_ack: valid=%b w0=%h w15=%h cnt=%0d ovf=%0d, want 1 41 50 4 5",
               f1_valid, word(f1_out, 0), word(f1_out, 15), f1_cnt, f1_ovf);
    end
    feed(32'h51, 2);
    n_checks++;
    if (f1_ovf !== 16'd5 || f1_cnt !== 16'd4 || word(f1_out, 0) !== 32'h41) begin
      n_fail++;
      $display("FAIL no_stall_after_ack: ovf=%0d cnt=%0d w0=%h, want 5 4 41",
               f1_ovf, f1_cnt, word(f1_out, 0));
    end
  endtask

  task automatic test_decim();
    logic [WIDTH-1:0] exp_w;
    do_reset();
    feed(32'h0, 64);
    n_checks++;
    if (f4_valid !== 1'b1 || f4_cnt !== 16'd1 || f4_ovf !== 16'd0 || f4_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL decim_frame: valid=%b cnt=%0d ovf=%0d bank=%b, want 1 1 0 1",
               f4_valid, f4_cnt, f4_ovf, f4_bank);
    end
    for (int k = 0; k < 16; k++) begin
      exp_w = WIDTH'(4 * k);
      n_checks++;
      if (word(f4_out, k) !== exp_w) begin
        n_fail++;
        $display("FAIL decim_word%0d: got %h, want %h", k, word(f4_out, k), exp_w);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed(32'h100, 7);
    do_reset();
    n_checks++;
    if (f1_valid !== 1'b0 || f1_cnt !== 16'd0 || f1_ovf !== 16'd0 || f1_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midframe: valid=%b cnt=%0d ovf=%0d bank=%b, want 0 0 0 0",
               f1_valid, f1_cnt, f1_ovf, f1_bank);
    end
    feed(32'h300, 16);
    n_checks++;
    if (f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h300 || word(f1_out, 15) !== 32'h30F ||
        f1_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL post_reset_frame: valid=%b w0=%h w15=%h cnt=%0d, want 1 300 30f 1",
               f1_valid, word(f1_out, 0), word(f1_out, 15), f1_cnt);
    end
    feed(32'h400, 18);
    n_checks++;
    if (f1_ovf !== 16'd2 || f1_valid !== 1'b1 || f1_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL stall_before_reset: ovf=%0d valid=%b cnt=%0d, want 2 1 1",
               f1_ovf, f1_valid, f1_cnt);
    end
    do_reset();
    n_checks++;
    if (f1_valid !== 1'b0 || f1_cnt !== 16'd0 || f1_ovf !== 16'd0 || f1_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_stall: valid=%b cnt=%0d ovf=%0d bank=%b, want 0 0 0 0",
               f1_valid, f1_cnt, f1_ovf, f1_bank);
    end
    feed(32'h200, 16);
    n_checks++;
    if (f1_valid !== 1'b1 || word(f1_out, 0) !== 32'h200 || word(f1_out, 15) !== 32'h20F ||
        f1_cnt !== 16'd1 || f1_ovf !== 16'd0) begin
      n_fail++;
      $display("FAIL post_stall_reset_frame: valid=%b w0=%h w15=%h cnt=%0d ovf=%0d, want 1 200 20f 1 0",
               f1_valid, word(f1_out, 0), word(f1_out, 15), f1_cnt, f1_ovf);
    end
  endtask

  initial begin
    reset = 1'b1; sample_in = '0; sample_valid = 1'b0; frame_ack = 1'b0;
    test_reset();
    test_first_frame();
    test_stall();
    test_mid_ack();
    test_back_to_back();
    test_decim();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
